// File: rtl/updn_sweep_pkg.sv
// updn_sweep_pkg: shared state encoding and default widths for the sweep controller.
package updn_sweep_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CW = 8;
    typedef enum logic [2:0] {IDLE, UP, DWELL_HI, DOWN, DWELL_LO, DONE} state_t;
endpackage

// File: rtl/updn_cnt.sv
// updn_cnt: up/down counter with synchronous load; holds when not enabled.
module updn_cnt import updn_sweep_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_o <= '0;
        else if (load_i) q_o <= lo_i;
        else if (en_i) q_o <= up_i ? q_o + WIDTH'(1) : q_o - WIDTH'(1);
    end
endmodule

// File: rtl/updn_sweep_ctrl.sv
// updn_sweep_ctrl: sequences updn_cnt through n triangle sweeps lo->hi->lo with
// programmable dwell at each peak, using configuration latched at start.
module updn_sweep_ctrl import updn_sweep_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW = DEF_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CW-1:0]    dwell,
    input  logic [CW-1:0]    n_sweeps,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CW-1:0]    sweep_cnt
);
    state_t state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, q_inc, q_dec;
    logic [CW-1:0] dwell_q, dwell_d, n_q, n_d, timer_q, timer_d, cnt_q, cnt_d, cnt_inc;
    logic dir_q, busy_q, done_q, err_q, err_d;
    logic load, en, up, at_lo, at_hi;
    updn_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk(clk), .rst(rst), .load_i(load), .lo_i(lo), .en_i(en), .up_i(up), .q_o(q)
    );
    assign q_inc = q + WIDTH'(1);
    assign q_dec = q - WIDTH'(1);
    assign cnt_inc = cnt_q + CW'(1);
    always_comb begin
        state_d = state_q;
        lo_d = lo_q;
        hi_d = hi_q;
        dwell_d = dwell_q;
        n_d = n_q;
        timer_d = timer_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        load = 1'b0;
        en = 1'b0;
        up = 1'b0;
        at_lo = 1'b0;
        at_hi = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && lo < hi && n_sweeps != '0) begin
                    lo_d = lo;
                    hi_d = hi;
                    dwell_d = dwell;
                    n_d = n_sweeps;
                    cnt_d = '0;
                    load = 1'b1;
                    state_d = UP;
                end else err_d = start;
            end
            UP: begin
                en = 1'b1;
                up = 1'b1;
                at_hi = q_inc == hi_q;
            end
            DWELL_HI: begin
                if (timer_q != '0) timer_d = timer_q - CW'(1);
                else begin
                    en = 1'b1;
                    state_d = DOWN;
                    at_lo = q_dec == lo_q;
                end
            end
            DOWN: begin
                en = 1'b1;
                at_lo = q_dec == lo_q;
            end
            DWELL_LO: begin
                if (timer_q != '0) timer_d = timer_q - CW'(1);
                else begin
                    en = 1'b1;
                    up = 1'b1;
                    state_d = UP;
                    at_hi = q_inc == hi_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // a one-step span means the peak exit lands directly on the opposite bound
        if (at_hi) begin
            state_d = DWELL_HI;
            timer_d = dwell_q;
        end
        if (at_lo) begin
            cnt_d = cnt_inc;
            state_d = cnt_inc == n_q ? DONE : DWELL_LO;
            timer_d = dwell_q;
        end
        if (abort && busy_q) begin
            state_d = IDLE;
            en = 1'b0;
            cnt_d = cnt_q;
            timer_d = timer_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q <= '0;
            hi_q <= '0;
            dwell_q <= '0;
            n_q <= '0;
            timer_q <= '0;
            cnt_q <= '0;
            dir_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q <= lo_d;
            hi_q <= hi_d;
            dwell_q <= dwell_d;
            n_q <= n_d;
            timer_q <= timer_d;
            cnt_q <= cnt_d;
            dir_q <= state_d == UP || state_d == DWELL_HI;
            busy_q <= state_d inside {UP, DWELL_HI, DOWN, DWELL_LO};
            done_q <= state_d == DONE;
            err_q <= err_d;
        end
    end
    assign dir = dir_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign sweep_cnt = cnt_q;
endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// tb_updn_sweep_ctrl: directed scenarios with hand-computed count traces.
module tb_updn_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0;
    logic [3:0] lo = '0, hi = '0, q;
    logic [7:0] dwell = '0, n_sweeps = '0, sweep_cnt;
    logic dir, busy, done, err;
    int checks = 0, failures = 0;

    updn_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .lo(lo), .hi(hi),
        .dwell(dwell), .n_sweeps(n_sweeps), .q(q), .dir(dir), .busy(busy),
        .done(done), .err(err), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic go(input logic [3:0] l, input logic [3:0] h, input logic [7:0] d, input logic [7:0] n);
        lo = l; hi = h; dwell = d; n_sweeps = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if ({q, dir, busy, done, err} !== 8'h00) begin failures++; $display("FAIL reset_outs got=%h exp=00", {q, dir, busy, done, err}); end
        checks++; if (sweep_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", sweep_cnt); end
        rst = 1'b0;
        @(negedge clk);
        go(4'd1, 4'd6, 8'd0, 8'd1);
        repeat (2) @(negedge clk);
        checks++; if (q !== 4'd3 || busy !== 1'b1) begin failures++; $display("FAIL pre_rst q=%0d busy=%b exp q=3 busy=1", q, busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_rst q=%0d busy=%b done=%b exp 0 0 0", q, busy, done); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL post_rst q=%0d busy=%b done=%b exp 0 0 0", q, busy, done); end
        end
    endtask

    task automatic test_full_range;
        int done_edge = -1, n15 = 0, npulse = 0;
        logic [7:0] cnt_at_done = '0;
        go(4'd0, 4'd15, 8'd0, 8'd2);
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (q == 4'd15) n15++;
            if (done) begin
                npulse++;
                if (done_edge < 0) begin done_edge = i; cnt_at_done = sweep_cnt; end
            end
            if (i == 31) begin
                checks++; if (q !== 4'd1 || dir !== 1'b1) begin failures++; $display("FAIL full_resweep q=%0d dir=%b exp q=1 dir=1", q, dir); end
            end
        end
        checks++; if (done_edge != 60) begin failures++; $display("FAIL full_done_edge got=%0d exp=60", done_edge); end
        checks++; if (n15 != 2) begin failures++; $display("FAIL full_peak_cycles got=%0d exp=2", n15); end
        checks++; if (npulse != 1) begin failures++; $display("FAIL full_done_pulses got=%0d exp=1", npulse); end
        checks++; if (cnt_at_done !== 8'd2) begin failures++; $display("FAIL full_sweep_cnt got=%0d exp=2", cnt_at_done); end
    endtask

    task automatic test_basic;
        logic [3:0] eq [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2};
        logic ed [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        go(4'd2, 4'd5, 8'd1, 8'd1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (q !== eq[i] || dir !== ed[i] || done !== (i == 7)) begin failures++; $display("FAIL basic_e%0d q=%0d dir=%b done=%b exp q=%0d dir=%b done=%b", i, q, dir, done, eq[i], ed[i], i == 7); end
        end
        checks++; if (sweep_cnt !== 8'd1 || busy !== 1'b0) begin failures++; $display("FAIL basic_end cnt=%0d busy=%b exp 1 0", sweep_cnt, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || q !== 4'd2) begin failures++; $display("FAIL basic_after done=%b q=%0d exp 0 2", done, q); end
    endtask

    task automatic test_err;
        go(4'd7, 4'd7, 8'd0, 8'd1);
        checks++; if (err !== 1'b1 || busy !== 1'b0 || q !== 4'd2) begin failures++; $display("FAIL err_eq err=%b busy=%b q=%0d exp 1 0 2", err, busy, q); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", err); end
        go(4'd1, 4'd5, 8'd0, 8'd0);
        checks++; if (err !== 1'b1 || busy !== 1'b0 || q !== 4'd2) begin failures++; $display("FAIL err_n0 err=%b busy=%b q=%0d exp 1 0 2", err, busy, q); end
        @(negedge clk);
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL err_n0_after err=%b busy=%b exp 0 0", err, busy); end
    endtask

    task automatic test_abort;
        go(4'd1, 4'd6, 8'd0, 8'd1);
        repeat (7) @(negedge clk);
        checks++; if (q !== 4'd4 || dir !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre q=%0d dir=%b busy=%b exp 4 0 1", q, dir, busy); end
        abort = 1'b1; start = 1'b1; lo = 4'd0; hi = 4'd3; n_sweeps = 8'd1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (q !== 4'd4 || busy !== 1'b0 || done !== 1'b0 || sweep_cnt !== 8'd0) begin failures++; $display("FAIL abort_c%0d q=%0d busy=%b done=%b cnt=%0d exp 4 0 0 0", i, q, busy, done, sweep_cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] eq [11] = '{4'd3, 4'd4, 4'd4, 4'd4, 4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd3};
        go(4'd3, 4'd4, 8'd2, 8'd2);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                start = (i == 4);
                lo = 4'd0; hi = 4'd9;
                @(negedge clk);
                start = 1'b0;
            end
            checks++; if (q !== eq[i] || done !== (i == 10)) begin failures++; $display("FAIL b2b_e%0d q=%0d done=%b exp q=%0d done=%b", i, q, done, eq[i], i == 10); end
        end
        checks++; if (sweep_cnt !== 8'd2 || busy !== 1'b0) begin failures++; $display("FAIL b2b_end cnt=%0d busy=%b exp 2 0", sweep_cnt, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== 4'd3) begin failures++; $display("FAIL b2b_after done=%b busy=%b q=%0d exp 0 0 3", done, busy, q); end
    endtask

    initial begin
        test_reset;
        test_full_range;
        test_basic;
        test_err;
        test_abort;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
